imem_dmem_arbiter: RTL and testbench

//  Shares one memory port between the fetch unit (instrman) and the load/store unit.

---
 rtl/imem_dmem_arbiter_pkg.sv | 21 ++
 rtl/imem_dmem_arbiter_if.sv | 27 ++
 rtl/imem_dmem_arbiter_arb_owner_fifo.sv | 51 +++++
 rtl/imem_dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter.
//   XLEN, BUS_WID : address and data widths of the shared memory port
//   owner_t       : owner tag stored per in-flight request (OWN_I fetch, OWN_D data)
//   slot_t        : one held request (valid, write enable, address, write data)
package imem_dmem_arbiter_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BUS_WID = 32;

    typedef logic owner_t;
    localparam owner_t OWN_I = 1'b0;
    localparam owner_t OWN_D = 1'b1;

    typedef struct packed {
        logic               valid;
        logic               we;
        logic [XLEN-1:0]    addr;
        logic [BUS_WID-1:0] wdata;
    } slot_t;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Shared memory port bundle.
//   req/we/addr/wdata : request side, driven by the arbiter (master)
//   gnt               : memory accepts the request this cycle
//   rdata/resp/err    : in-order response, driven by the memory (slave)
interface imem_dmem_arbiter_if;
    import imem_dmem_arbiter_pkg::*;

    logic               req;
    logic               gnt;
    logic               we;
    logic [XLEN-1:0]    addr;
    logic [BUS_WID-1:0] wdata;
    logic [BUS_WID-1:0] rdata;
    logic               resp;
    logic               err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rdata, resp, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdata, resp, err
    );

endinterface

// File: rtl/imem_dmem_arbiter_arb_owner_fifo.sv
// Owner FIFO, 1 bit wide, depth 2. Records which side owns each in-flight request.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the tail
//   push_data  : owner bit to store
//   pop        : drop the head (ignored when empty)
//   full/empty : occupancy flags
//   head       : current head entry
// Push and pop may coincide at any occupancy; a pop frees the full slot in time.
module arb_owner_fifo (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    logic [1:0] mem_q;
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] cnt_q;
    logic       pop_eff;
    logic       push_eff;

    assign full     = (cnt_q == 2'd2);
    assign empty    = (cnt_q == 2'd0);
    assign head     = mem_q[rd_ptr_q];
    assign pop_eff  = pop & ~empty;
    assign push_eff = push & (~full | pop_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= 2'b00;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_eff) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_eff) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push_eff} - {1'b0, pop_eff};
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between the fetch unit and the load/store unit.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i_req, i_addr               : fetch request pulse and aligned address
//   i_rdata, i_resp, i_err      : fetch response (rdata qualified by i_resp)
//   d_req, d_we, d_addr, d_wdata: data request pulse and fields
//   d_rdata, d_resp, d_err      : data response (rdata qualified by d_resp)
//   mem                         : shared memory port (req/gnt, in-order resp)
// Each side has one holding slot; a live request may bypass its slot when it wins
// and is granted in the same cycle. Data has priority until it has taken STARVE_LIM
// consecutive grants over a pending fetch.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [XLEN-1:0]      i_addr,
    output logic [BUS_WID-1:0]   i_rdata,
    output logic                 i_resp,
    output logic                 i_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [XLEN-1:0]      d_addr,
    input  logic [BUS_WID-1:0]   d_wdata,
    output logic [BUS_WID-1:0]   d_rdata,
    output logic                 d_resp,
    output logic                 d_err,
    imem_dmem_arbiter_if.master  mem
);

    localparam int unsigned StW = $clog2(STARVE_LIM + 1);
    localparam logic [StW-1:0] StarveMax = StW'(STARVE_LIM);

    slot_t          i_slot_q, i_slot_d;
    slot_t          d_slot_q, d_slot_d;
    slot_t          i_cand, d_cand, win_slot;
    owner_t         win;
    logic [StW-1:0] starve_q, starve_d;
    logic           lock_q, lock_d;
    owner_t         lock_own_q;
    logic           grant;
    logic           fifo_full, fifo_empty;
    owner_t         fifo_head;
    logic           resp_ok;

    always_comb begin
        i_cand = i_slot_q.valid ? i_slot_q
                                : '{valid: i_req, we: 1'b0, addr: i_addr, wdata: '0};
        d_cand = d_slot_q.valid ? d_slot_q
                                : '{valid: d_req, we: d_we, addr: d_addr, wdata: d_wdata};

        // A request shown without a grant keeps its place until it is taken.
        if (lock_q) begin
            win = lock_own_q;
        end else if (i_cand.valid && d_cand.valid) begin
            win = (starve_q == StarveMax) ? OWN_I : OWN_D;
        end else begin
            win = d_cand.valid ? OWN_D : OWN_I;
        end
        win_slot = (win == OWN_D) ? d_cand : i_cand;

        mem.req   = rst_n & (i_cand.valid | d_cand.valid) & ~fifo_full;
        mem.we    = win_slot.we;
        mem.addr  = win_slot.addr;
        mem.wdata = win_slot.wdata;
        grant     = mem.req & mem.gnt;
        lock_d    = mem.req & ~mem.gnt;

        i_slot_d = i_slot_q;
        if (grant && win == OWN_I) begin
            i_slot_d.valid = 1'b0;
        end else if (i_req && !i_slot_q.valid) begin
            i_slot_d = '{valid: 1'b1, we: 1'b0, addr: i_addr, wdata: '0};
        end

        d_slot_d = d_slot_q;
        if (grant && win == OWN_D) begin
            d_slot_d.valid = 1'b0;
        end else if (d_req && !d_slot_q.valid) begin
            d_slot_d = '{valid: 1'b1, we: d_we, addr: d_addr, wdata: d_wdata};
        end

        starve_d = starve_q;
        if (!i_cand.valid || (grant && win == OWN_I)) begin
            starve_d = '0;
        end else if (grant && win == OWN_D && starve_q != StarveMax) begin
            starve_d = starve_q + StW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_slot_q   <= '0;
            d_slot_q   <= '0;
            starve_q   <= '0;
            lock_q     <= 1'b0;
            lock_own_q <= OWN_I;
        end else begin
            i_slot_q   <= i_slot_d;
            d_slot_q   <= d_slot_d;
            starve_q   <= starve_d;
            lock_q     <= lock_d;
            lock_own_q <= win;
        end
    end

    arb_owner_fifo u_owner_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (win),
        .pop       (mem.resp),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // A response with nothing in flight is dropped.
    assign resp_ok = mem.resp & ~fifo_empty;
    assign i_resp  = resp_ok & (fifo_head == OWN_I);
    assign d_resp  = resp_ok & (fifo_head == OWN_D);
    assign i_err   = i_resp & mem.err;
    assign d_err   = d_resp & mem.err;
    assign i_rdata = mem.rdata;
    assign d_rdata = mem.rdata;

    a_i_req_slot_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_req && i_slot_q.valid));
    a_d_req_slot_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(d_req && d_slot_q.valid));
    a_resp_fifo_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem.resp && fifo_empty));

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;
    import imem_dmem_arbiter_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_req = 1'b0;
    logic [XLEN-1:0]    i_addr = '0;
    logic [BUS_WID-1:0] i_rdata;
    logic               i_resp, i_err;
    logic               d_req = 1'b0;
    logic               d_we = 1'b0;
    logic [XLEN-1:0]    d_addr = '0;
    logic [BUS_WID-1:0] d_wdata = '0;
    logic [BUS_WID-1:0] d_rdata;
    logic               d_resp, d_err;

    imem_dmem_arbiter_if mem_bus ();

    imem_dmem_arbiter #(.STARVE_LIM(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_resp  (i_resp),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_resp  (d_resp),
        .d_err   (d_err),
        .mem     (mem_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 2;
    int gnt_cnt = 0;
    int gnt_cyc_i = 0;
    int resp_cyc_i = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] data; logic err; } exp_t;

    logic [31:0] rd_tab [logic [31:0]];
    logic        er_tab [logic [31:0]];
    pend_t       pend_q [$];
    exp_t        exp_i [$];
    exp_t        exp_d [$];
    owner_t      order_q [$];
    logic [31:0] grant_log [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Fetch addresses are 0x1xx, data addresses 0x2xx.
    function automatic owner_t own_of(input logic [31:0] a);
        return a[9] ? OWN_D : OWN_I;
    endfunction

    // Memory model: in-order responses lat cycles after each grant.
    initial begin
        mem_bus.resp  = 1'b0;
        mem_bus.rdata = '0;
        mem_bus.err   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_bus.resp  = 1'b0;
            mem_bus.rdata = '0;
            mem_bus.err   = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                pend_t p;
                p = pend_q.pop_front();
                mem_bus.resp  = 1'b1;
                mem_bus.rdata = rd_tab.exists(p.addr) ? rd_tab[p.addr] : 32'h0;
                mem_bus.err   = er_tab.exists(p.addr) ? er_tab[p.addr] : 1'b0;
            end
        end
    end

    // Monitor: scoreboard compare on every response, then log grants.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (i_resp && d_resp) begin
                    checks++; errors++;
                    $display("FAIL dual_resp: got i_resp=1 d_resp=1, required one side");
                end
                if (i_resp) begin
                    resp_cyc_i = cyc;
                    if (exp_i.size() == 0 || order_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL i_resp_unexpected: got i_resp=1, required none");
                    end else begin
                        exp_t e;
                        e = exp_i.pop_front();
                        check("i_route", OWN_I, order_q.pop_front());
                        check("i_rdata", i_rdata, e.data);
                        check("i_err", i_err, e.err);
                        check("d_err_on_i", d_err, 1'b0);
                    end
                end
                if (d_resp) begin
                    if (exp_d.size() == 0 || order_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL d_resp_unexpected: got d_resp=1, required none");
                    end else begin
                        exp_t e;
                        e = exp_d.pop_front();
                        check("d_route", OWN_D, order_q.pop_front());
                        check("d_rdata", d_rdata, e.data);
                        check("d_err", d_err, e.err);
                        check("i_err_on_d", i_err, 1'b0);
                    end
                end
                if (mem_bus.req && mem_bus.gnt) begin
                    pend_q.push_back('{addr: mem_bus.addr, due: cyc + lat});
                    order_q.push_back(own_of(mem_bus.addr));
                    grant_log.push_back(mem_bus.addr);
                    gnt_cnt++;
                    if (own_of(mem_bus.addr) == OWN_I) gnt_cyc_i = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish within budget");
        $fatal(1, "timeout");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic issue_i(input logic [31:0] a, input logic [31:0] data, input logic err);
        rd_tab[a] = data;
        er_tab[a] = err;
        exp_i.push_back('{data: data, err: err});
        i_req  = 1'b1;
        i_addr = a;
    endtask

    task automatic issue_d(input logic [31:0] a, input logic we, input logic [31:0] wdata,
                           input logic [31:0] data, input logic err);
        rd_tab[a] = data;
        er_tab[a] = err;
        exp_d.push_back('{data: data, err: err});
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wdata;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_i.size() != 0 || exp_d.size() != 0) && n < 40) begin
            next_cycle();
            n++;
        end
        checks++;
        if (exp_i.size() != 0 || exp_d.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d/%0d responses outstanding, required 0/0",
                     name, exp_i.size(), exp_d.size());
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_mem_req"}, mem_bus.req, 1'b0);
        check({name, "_i_resp"}, i_resp, 1'b0);
        check({name, "_d_resp"}, d_resp, 1'b0);
        check({name, "_i_err"}, i_err, 1'b0);
        check({name, "_d_err"}, d_err, 1'b0);
    endtask

    int base;
    int g0;

    initial begin
        mem_bus.gnt = 1'b1;
        #12;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        next_cycle();

        // 1: single fetch, response 2 cycles after grant
        lat = 2;
        issue_i(32'h100, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check("t1_mem_req", mem_bus.req, 1'b1);
        check("t1_mem_addr", mem_bus.addr, 32'h100);
        check("t1_mem_we", mem_bus.we, 1'b0);
        next_cycle();
        drain("t1");
        check("t1_resp_latency", resp_cyc_i - gnt_cyc_i, 2);

        // 2: simultaneous requests, data first
        base = grant_log.size();
        issue_i(32'h104, 32'h11111111, 1'b0);
        issue_d(32'h200, 1'b0, 32'h0, 32'h22222222, 1'b0);
        @(negedge clk);
        check("t2_first_addr", mem_bus.addr, 32'h200);
        next_cycle();
        @(negedge clk);
        check("t2_second_req", mem_bus.req, 1'b1);
        check("t2_second_addr", mem_bus.addr, 32'h104);
        next_cycle();
        drain("t2");
        check("t2_log_n", grant_log.size() - base, 2);

        // 3: fetch starved by back-to-back data, lat=1 keeps data always pending
        lat = 1;
        base = grant_log.size();
        issue_i(32'h108, 32'h33333333, 1'b0);
        issue_d(32'h210, 1'b0, 32'h0, 32'hA0000000, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            issue_d(32'h210 + 32'(4 * k), 1'b0, 32'h0, 32'hA0000000 + 32'(k), 1'b0);
        end
        next_cycle();
        drain("t3");
        if (grant_log.size() - base == 6) begin
            check("t3_g0", grant_log[base + 0], 32'h210);
            check("t3_g1", grant_log[base + 1], 32'h214);
            check("t3_g2", grant_log[base + 2], 32'h218);
            check("t3_g3", grant_log[base + 3], 32'h21C);
            check("t3_g4", grant_log[base + 4], 32'h108);
            check("t3_g5", grant_log[base + 5], 32'h220);
        end else begin
            check("t3_log_n", grant_log.size() - base, 6);
        end
        // Starve counter back at 0: data wins again when both arrive together.
        lat = 2;
        issue_i(32'h10C, 32'h44444444, 1'b0);
        issue_d(32'h224, 1'b0, 32'h0, 32'h55555555, 1'b0);
        @(negedge clk);
        check("t3_starve_cleared", mem_bus.addr, 32'h224);
        next_cycle();
        drain("t3b");

        // 4: no grant for 3 cycles; a late data request must not steal the slot
        base = grant_log.size();
        mem_bus.gnt = 1'b0;
        g0 = gnt_cnt;
        issue_i(32'h110, 32'h66666666, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) issue_d(32'h228, 1'b0, 32'h0, 32'h77777777, 1'b0);
            @(negedge clk);
            check("t4_hold_req", mem_bus.req, 1'b1);
            check("t4_hold_addr", mem_bus.addr, 32'h110);
            next_cycle();
        end
        check("t4_no_grant", gnt_cnt - g0, 0);
        mem_bus.gnt = 1'b1;
        @(negedge clk);
        check("t4_gnt_addr", mem_bus.addr, 32'h110);
        next_cycle();
        check("t4_one_grant", gnt_cnt - g0, 1);
        drain("t4");
        if (grant_log.size() - base == 2) begin
            check("t4_g1", grant_log[base + 1], 32'h228);
        end else begin
            check("t4_log_n", grant_log.size() - base, 2);
        end

        // 5: error routing, and a write
        issue_i(32'h114, 32'h5555AAAA, 1'b1);
        next_cycle();
        drain("t5a");
        issue_d(32'h22C, 1'b0, 32'h0, 32'h12345678, 1'b0);
        next_cycle();
        drain("t5b");
        issue_d(32'h230, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0);
        @(negedge clk);
        check("t5_mem_we", mem_bus.we, 1'b1);
        check("t5_mem_wdata", mem_bus.wdata, 32'hCAFEF00D);
        next_cycle();
        drain("t5c");

        // 6: reset with two requests in flight
        lat = 6;
        issue_i(32'h118, 32'h0BAD0BAD, 1'b0);
        issue_d(32'h234, 1'b0, 32'h0, 32'h0BADBEEF, 1'b0);
        next_cycle();
        next_cycle();
        check("t6_outstanding", pend_q.size(), 2);
        rst_n = 1'b0;
        pend_q.delete();
        exp_i.delete();
        exp_d.delete();
        order_q.delete();
        #1;
        check_outputs_zero("t6_reset");
        next_cycle();
        rst_n = 1'b1;
        lat = 2;
        next_cycle();
        issue_i(32'h11C, 32'h600DF00D, 1'b0);
        next_cycle();
        drain("t6");

        repeat (3) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
